rpn_sequencer: RTL and testbench
================================

Name: rpn_sequencer

Overview:
- Command initiator for the 16-bit RPN stack calculator.
- Holds a small program of push/op instructions loaded through a write port.
- On start, it clears the calculator, then issues one instruction per clock and checks stack depth before each issue.
- It captures the final top-of-stack as the result, and flags underflow, overflow and a runaway program.

Parameters:
PROG_AW, 8, program memory address width (2^PROG_AW instruction words)
DW, 16, data width (calculator operand width)
CNT_W, 10, calculator depth-counter width; calculator full when count = 2^CNT_W-1

Ports:
step  input  1  clock, all state updates on posedge step
nrst  input  1  synchronous active-low reset, sampled on posedge step
start  input  1  begin program execution (level sampled per edge)
prog_wr  input  1  program write strobe
prog_addr  input  PROG_AW  program write address
prog_data  input  DW+2  instruction word written
busy  output  1  high in CLR and RUN states
done  output  1  high in DONE state
err  output  1  high in ERR state
result  output  DW  top-of-stack captured at END
calc_nrst  output  1  drives calculator reset; low while nrst low or in CLR
calc_push  output  1  calculator push
calc_d  output  DW  calculator push data
calc_op  output  2  calculator op (0 nop, 1 negate, 2 add, 3 multiply)
calc_cnt  input  CNT_W  calculator depth
calc_out  input  DW  calculator top-of-stack
icount  output  16  issued-instruction count (see Optional Feature)

Behaviour:
- Instruction encoding, bits [DW+1:DW] select the kind:
  - 00: PUSH imm=[DW-1:0].
  - 01: OP, op=[1:0].
  - 10: END.
  - 11: NOP.
- Program memory:
  - 2^PROG_AW x (DW+2), combinational read at pc.
  - Write on posedge step when prog_wr && !busy.
  - Writes while busy are dropped.
  - Contents not cleared by reset.
- FSM states: IDLE, CLR, RUN, DONE, ERR.
- Reset (nrst low at edge):
  - state IDLE, pc 0, result 0, icount 0.
  - Outputs busy=0, done=0, err=0.
  - Reset mid-RUN aborts immediately.
- IDLE/DONE/ERR with start=1 -> CLR, pc<=0, icount<=0.
  - done/err drop on that edge.
  - result holds its old value until the next END.
- CLR lasts exactly one cycle:
  - calc_nrst=0, so the calculator clears on the same edge.
  - -> RUN.
- RUN: per cycle decode instr[pc] and drive calc_* combinationally; the calculator executes on the same edge.
  - PUSH:
    - If calc_cnt = 2^CNT_W-1 -> ERR, calc_push forced 0.
    - Else calc_push=1, calc_d=imm, pc++.
  - OP:
    - op 2/3 with calc_cnt < 2 -> ERR, calc_op forced 0.
    - op 1 with calc_cnt = 0 is legal (the calculator negates its zero top).
    - Else calc_op=op, pc++.
  - NOP: pc++, calc_op=0.
  - END: result <= calc_out, -> DONE.
  - pc wrap (incrementing from 2^PROG_AW-1 without END) -> ERR.
  - start is ignored in RUN.
- Outside RUN: calc_push=0, calc_op=0, calc_d=0.
- calc_nrst = nrst && state!=CLR.
- Latency:
  - start edge E0, CLR cycle, RUN from E1.
  - A program of n non-END instructions plus END gives done=1 after edge E0+n+2.

Optional Feature:
- Macro RPN_SEQ_ICOUNT_EN.
- Defined: icount increments on every RUN edge that issues PUSH/OP/NOP.
  - It saturates at 16'hFFFF.
  - It is cleared on start and on reset.
  - It holds in DONE/ERR.
- Undefined: icount tied to 0, no counter flops.

Decomposition:
- Package rpn_pkg holds:
  - kind enum (KIND_PUSH, KIND_OP, KIND_END, KIND_NOP);
  - op enum (OP_NOP, OP_NEG, OP_ADD, OP_MUL);
  - state enum;
  - instruction packed struct;
  - DW/CNT_W defaults.
- One sub-module rpn_prog_mem: program RAM, synchronous write, combinational read.

Test Plan:
- Program PUSH 3, PUSH 4, OP 2, END; start -> done at E0+5, result=16'h0007, err=0, icount=3.
- Program PUSH 5, OP 1, PUSH 3, OP 3, END -> result=16'hFFF1 (-15), done=1.
- Program PUSH 1, OP 2 -> err=1 on edge issuing OP, calc_op=0 that cycle, calc_cnt stays 1, done=0.
- Program of all NOPs (no END), PROG_AW=8 -> err=1 after 256 RUN cycles, busy low afterwards.
- Reset mid-RUN (nrst low one edge) -> IDLE, busy=0, result=0, calc_nrst low that cycle. prog_wr during RUN leaves memory unchanged (read back via rerun).
- After DONE, start again with same program -> CLR cycle observed (calc_nrst=0), identical result, done reasserts.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared types for the RPN calculator sequencer: instruction kinds, ALU ops,
// sequencer states and the default-width instruction word layout.
package rpn_pkg;

   localparam int DW_DEF      = 16;
   localparam int CNT_W_DEF   = 10;
   localparam int PROG_AW_DEF = 8;

   typedef enum logic [1:0] {
      KIND_PUSH = 2'b00,
      KIND_OP   = 2'b01,
      KIND_END  = 2'b10,
      KIND_NOP  = 2'b11
   } kind_t;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_NEG = 2'd1,
      OP_ADD = 2'd2,
      OP_MUL = 2'd3
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CLR  = 3'd1,
      ST_RUN  = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   typedef struct packed {
      kind_t              kind;
      logic [DW_DEF-1:0]  imm;
   } instr_t;

   function automatic logic [DW_DEF+1:0] mk_instr(kind_t kind, logic [DW_DEF-1:0] imm);
      instr_t i;
      i.kind = kind;
      i.imm  = imm;
      return i;
   endfunction

endpackage

// File: rtl/rpn_sequencer_if.sv
// Calculator-side bus of the RPN sequencer: clear, push/op issue and the
// calculator's depth and top-of-stack returned to the sequencer.
interface rpn_sequencer_if #(
   parameter int DW    = 16,
   parameter int CNT_W = 10
);
   logic             calc_nrst;
   logic             calc_push;
   logic [DW-1:0]    calc_d;
   logic [1:0]       calc_op;
   logic [CNT_W-1:0] calc_cnt;
   logic [DW-1:0]    calc_out;

   modport master (
      output calc_nrst, calc_push, calc_d, calc_op,
      input  calc_cnt, calc_out
   );

   modport slave (
      input  calc_nrst, calc_push, calc_d, calc_op,
      output calc_cnt, calc_out
   );
endinterface

// File: rtl/rpn_prog_mem.sv
// Program RAM for the RPN sequencer: synchronous write, combinational read,
// contents survive reset.
module rpn_prog_mem #(
   parameter int AW = 8,
   parameter int W  = 18
) (
   input  logic          step,
   input  logic          wr,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [2**AW];

   always_ff @(posedge step) begin
      if (wr) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rpn_sequencer.sv
// RPN calculator command sequencer: clears the calculator, issues one program
// instruction per cycle with stack-depth guards, captures the result at END.
// Optional issued-instruction counter enabled by RPN_SEQ_ICOUNT_EN.
//
// state   | meaning
// IDLE    | waiting for start
// CLR     | one cycle holding the calculator in reset
// RUN     | issuing instr[pc] each cycle
// DONE    | END reached, result valid
// ERR     | underflow, overflow or pc wrap without END
module rpn_sequencer
   import rpn_pkg::*;
#(
   parameter int PROG_AW = 8,
   parameter int DW      = 16,
   parameter int CNT_W   = 10
) (
   input  logic               step,
   input  logic               nrst,
   input  logic               start,
   input  logic               prog_wr,
   input  logic [PROG_AW-1:0] prog_addr,
   input  logic [DW+1:0]      prog_data,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [DW-1:0]      result,
   rpn_sequencer_if.master    calc,
   output logic [15:0]        icount
);

   localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

   state_t             state, state_nx;
   logic [PROG_AW-1:0] pc, pc_nx;
   logic [DW-1:0]      result_nx;
   logic [DW+1:0]      instr;
   kind_t              kind;
   op_t                op;
   logic               issue;
   logic               restart;

   rpn_prog_mem #(.AW(PROG_AW), .W(DW+2)) u_prog_mem (
      .step  (step),
      .wr    (prog_wr && !busy),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (pc),
      .rdata (instr)
   );

   assign kind    = kind_t'(instr[DW+1:DW]);
   assign op      = op_t'(instr[1:0]);
   assign restart = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

   always_ff @(posedge step) begin
      if (!nrst) begin
         state  <= ST_IDLE;
         pc     <= '0;
         result <= '0;
      end else begin
         state  <= state_nx;
         pc     <= pc_nx;
         result <= result_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      pc_nx          = pc;
      result_nx      = result;
      issue          = 1'b0;
      calc.calc_push = 1'b0;
      calc.calc_d    = '0;
      calc.calc_op   = OP_NOP;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (restart) begin
               state_nx = ST_CLR;
               pc_nx    = '0;
            end
         end
         ST_CLR: state_nx = ST_RUN;
         ST_RUN: begin
            case (kind)
               KIND_PUSH: begin
                  if (calc.calc_cnt == CNT_FULL) begin
                     state_nx = ST_ERR;
                  end else begin
                     calc.calc_push = 1'b1;
                     calc.calc_d    = instr[DW-1:0];
                     issue          = 1'b1;
                  end
               end
               KIND_OP: begin
                  // Negate on an empty stack is legal; binary ops need two operands.
                  if ((op == OP_ADD || op == OP_MUL) && calc.calc_cnt < CNT_W'(2)) begin
                     state_nx = ST_ERR;
                  end else begin
                     calc.calc_op = op;
                     issue        = 1'b1;
                  end
               end
               KIND_NOP: issue = 1'b1;
               default: begin
                  result_nx = calc.calc_out;
                  state_nx  = ST_DONE;
               end
            endcase
            if (issue) begin
               pc_nx = pc + 1'b1;
               if (pc == {PROG_AW{1'b1}}) state_nx = ST_ERR;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign busy           = (state == ST_CLR) || (state == ST_RUN);
   assign done           = (state == ST_DONE);
   assign err            = (state == ST_ERR);
   assign calc.calc_nrst = nrst && (state != ST_CLR);

`ifdef RPN_SEQ_ICOUNT_EN
   logic [15:0] icount_q;

   always_ff @(posedge step) begin
      if (!nrst || restart) icount_q <= '0;
      else if (issue && icount_q != 16'hFFFF) icount_q <= icount_q + 16'd1;
   end

   assign icount = icount_q;
`else
   assign icount = '0;
`endif

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed self-checking bench for rpn_sequencer with a behavioural RPN
// calculator model attached to the calculator bus.
module tb_rpn_sequencer;
   import rpn_pkg::*;

   localparam int PROG_AW = 8;
   localparam int DW      = 16;
   localparam int CNT_W   = 10;
`ifdef RPN_SEQ_ICOUNT_EN
   localparam bit ICNT = 1'b1;
`else
   localparam bit ICNT = 1'b0;
`endif

   logic               step = 1'b0;
   logic               nrst;
   logic               start;
   logic               prog_wr;
   logic [PROG_AW-1:0] prog_addr;
   logic [DW+1:0]      prog_data;
   logic               busy, done, err;
   logic [DW-1:0]      result;
   logic [15:0]        icount;

   int n_tests = 0;
   int n_fail  = 0;

   rpn_sequencer_if #(.DW(DW), .CNT_W(CNT_W)) calc_bus ();

   rpn_sequencer #(.PROG_AW(PROG_AW), .DW(DW), .CNT_W(CNT_W)) dut (
      .step      (step),
      .nrst      (nrst),
      .start     (start),
      .prog_wr   (prog_wr),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .result    (result),
      .calc      (calc_bus),
      .icount    (icount)
   );

   always #5 step = ~step;

   // Behavioural calculator
   logic [DW-1:0] stk [1024];
   int            cnt = 0;
   logic          force_full = 1'b0;

   assign calc_bus.calc_cnt = force_full ? {CNT_W{1'b1}} : CNT_W'(cnt);
   assign calc_bus.calc_out = (cnt > 0) ? stk[cnt-1] : '0;

   always @(posedge step) begin
      if (!calc_bus.calc_nrst) begin
         cnt <= 0;
      end else if (calc_bus.calc_push) begin
         if (cnt < 1023) begin
            stk[cnt] <= calc_bus.calc_d;
            cnt      <= cnt + 1;
         end
      end else begin
         case (calc_bus.calc_op)
            2'd1: if (cnt > 0) stk[cnt-1] <= -stk[cnt-1];
            2'd2: if (cnt > 1) begin
               stk[cnt-2] <= stk[cnt-2] + stk[cnt-1];
               cnt        <= cnt - 1;
            end
            2'd3: if (cnt > 1) begin
               stk[cnt-2] <= DW'(stk[cnt-2] * stk[cnt-1]);
               cnt        <= cnt - 1;
            end
            default: ;
         endcase
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic write_word(input int addr, input logic [DW+1:0] data);
      @(negedge step);
      prog_wr   = 1'b1;
      prog_addr = PROG_AW'(addr);
      prog_data = data;
      @(negedge step);
      prog_wr   = 1'b0;
   endtask

   // Returns after the start edge E0 (sequencer now in CLR)
   task automatic pulse_start();
      @(negedge step);
      start = 1'b1;
      @(negedge step);
      start = 1'b0;
   endtask

   // c = number of edges after E0 at which done or err was first seen
   task automatic wait_end(input int max, output int c);
      c = 0;
      do begin
         @(negedge step);
         c++;
      end while (!(done || err) && c < max);
   endtask

   task automatic test_reset();
      nrst = 1'b0; start = 1'b0; prog_wr = 1'b0; prog_addr = '0; prog_data = '0;
      #1;
      n_tests++;
      if (calc_bus.calc_nrst !== 1'b0) begin n_fail++; $display("FAIL reset_calc_nrst: got %b want 0", calc_bus.calc_nrst); end
      repeat (2) @(negedge step);
      n_tests++;
      if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
      n_tests++;
      if (result !== 16'h0000 || icount !== 16'h0000) begin n_fail++; $display("FAIL reset_regs: result %h icount %h want 0 0", result, icount); end
      nrst = 1'b1;
      @(negedge step);
   endtask

   task automatic test_add();
      int c;
      write_word(0, mk_instr(KIND_PUSH, 16'd3));
      write_word(1, mk_instr(KIND_PUSH, 16'd4));
      write_word(2, mk_instr(KIND_OP, 16'd2));
      write_word(3, mk_instr(KIND_END, 16'd0));
      pulse_start();
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_clr: got %b want 1", busy); end
      wait_end(20, c);
      n_tests++;
      if (c !== 5 || done !== 1'b1) begin n_fail++; $display("FAIL add_latency: got edge %0d done %b want 5 1", c, done); end
      n_tests++;
      if (result !== 16'h0007 || err !== 1'b0) begin n_fail++; $display("FAIL add_result: got %h err %b want 0007 0", result, err); end
      n_tests++;
      if (icount !== (ICNT ? 16'd3 : 16'd0)) begin n_fail++; $display("FAIL add_icount: got %0d want %0d", icount, ICNT ? 3 : 0); end
   endtask

   task automatic test_neg_mul();
      int c;
      write_word(0, mk_instr(KIND_PUSH, 16'd5));
      write_word(1, mk_instr(KIND_OP, 16'd1));
      write_word(2, mk_instr(KIND_PUSH, 16'd3));
      write_word(3, mk_instr(KIND_OP, 16'd3));
      write_word(4, mk_instr(KIND_END, 16'd0));
      pulse_start();
      wait_end(20, c);
      n_tests++;
      if (c !== 6 || done !== 1'b1) begin n_fail++; $display("FAIL negmul_latency: got edge %0d done %b want 6 1", c, done); end
      n_tests++;
      if (result !== 16'hFFF1) begin n_fail++; $display("FAIL negmul_result: got %h want fff1", result); end
   endtask

   task automatic test_underflow();
      write_word(0, mk_instr(KIND_PUSH, 16'd1));
      write_word(1, mk_instr(KIND_OP, 16'd2));
      write_word(2, mk_instr(KIND_END, 16'd0));
      pulse_start();
      repeat (2) @(negedge step);
      n_tests++;
      if (calc_bus.calc_op !== 2'd0 || calc_bus.calc_push !== 1'b0) begin n_fail++; $display("FAIL uflow_issue: got op %0d push %b want 0 0", calc_bus.calc_op, calc_bus.calc_push); end
      @(negedge step);
      n_tests++;
      if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL uflow_flags: got err %b done %b busy %b want 1 0 0", err, done, busy); end
      n_tests++;
      if (calc_bus.calc_cnt !== 10'd1) begin n_fail++; $display("FAIL uflow_cnt: got %0d want 1", calc_bus.calc_cnt); end
      n_tests++;
      if (icount !== (ICNT ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL uflow_icount: got %0d want %0d", icount, ICNT ? 1 : 0); end
   endtask

   task automatic test_neg_empty();
      int c;
      write_word(0, mk_instr(KIND_OP, 16'd1));
      write_word(1, mk_instr(KIND_END, 16'd0));
      pulse_start();
      wait_end(20, c);
      n_tests++;
      if (c !== 3 || done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL negempty: got edge %0d done %b err %b want 3 1 0", c, done, err); end
      n_tests++;
      if (result !== 16'h0000) begin n_fail++; $display("FAIL negempty_result: got %h want 0000", result); end
   endtask

   task automatic test_overflow();
      write_word(0, mk_instr(KIND_PUSH, 16'd9));
      write_word(1, mk_instr(KIND_END, 16'd0));
      force_full = 1'b1;
      pulse_start();
      @(negedge step);
      n_tests++;
      if (calc_bus.calc_push !== 1'b0) begin n_fail++; $display("FAIL oflow_push: got %b want 0", calc_bus.calc_push); end
      @(negedge step);
      n_tests++;
      if (err !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL oflow_flags: got err %b done %b want 1 0", err, done); end
      force_full = 1'b0;
   endtask

   task automatic test_no_end();
      int c;
      for (int i = 0; i < 256; i++) write_word(i, mk_instr(KIND_NOP, 16'd0));
      pulse_start();
      wait_end(400, c);
      n_tests++;
      if (c !== 257 || err !== 1'b1) begin n_fail++; $display("FAIL noend_wrap: got edge %0d err %b want 257 1", c, err); end
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL noend_busy: got busy %b done %b want 0 0", busy, done); end
      n_tests++;
      if (icount !== (ICNT ? 16'd256 : 16'd0)) begin n_fail++; $display("FAIL noend_icount: got %0d want %0d", icount, ICNT ? 256 : 0); end
   endtask

   task automatic test_reset_mid_run();
      int c;
      write_word(0, mk_instr(KIND_PUSH, 16'd3));
      write_word(1, mk_instr(KIND_PUSH, 16'd4));
      write_word(2, mk_instr(KIND_OP, 16'd2));
      write_word(3, mk_instr(KIND_END, 16'd0));
      pulse_start();
      wait_end(20, c);
      n_tests++;
      if (result !== 16'h0007) begin n_fail++; $display("FAIL rst_pre_result: got %h want 0007", result); end
      pulse_start();
      repeat (2) @(negedge step);
      nrst = 1'b0;
      #1;
      n_tests++;
      if (calc_bus.calc_nrst !== 1'b0) begin n_fail++; $display("FAIL rst_mid_calc_nrst: got %b want 0", calc_bus.calc_nrst); end
      @(negedge step);
      nrst = 1'b1;
      n_tests++;
      if (busy !== 1'b0 || result !== 16'h0000 || icount !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_state: busy %b result %h icount %0d want 0 0000 0", busy, result, icount); end
      // A write of END over the OP while busy must be dropped
      pulse_start();
      @(negedge step);
      prog_wr = 1'b1; prog_addr = 8'd2; prog_data = mk_instr(KIND_END, 16'd0);
      @(negedge step);
      prog_wr = 1'b0;
      wait_end(20, c);
      n_tests++;
      if (c + 2 !== 5 || result !== 16'h0007) begin n_fail++; $display("FAIL wr_busy_run: edge %0d result %h want 5 0007", c + 2, result); end
      pulse_start();
      wait_end(20, c);
      n_tests++;
      if (c !== 5 || result !== 16'h0007) begin n_fail++; $display("FAIL wr_busy_rerun: edge %0d result %h want 5 0007", c, result); end
   endtask

   task automatic test_back_to_back();
      int c;
      pulse_start();
      n_tests++;
      if (calc_bus.calc_nrst !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_clr: calc_nrst %b done %b busy %b want 0 0 1", calc_bus.calc_nrst, done, busy); end
      n_tests++;
      if (result !== 16'h0007) begin n_fail++; $display("FAIL b2b_hold: got %h want 0007", result); end
      wait_end(20, c);
      n_tests++;
      if (c !== 5 || done !== 1'b1 || result !== 16'h0007) begin n_fail++; $display("FAIL b2b_done: edge %0d done %b result %h want 5 1 0007", c, done, result); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_neg_mul();
      test_underflow();
      test_neg_empty();
      test_overflow();
      test_no_end();
      test_reset_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
